// File: rtl/image_filter_pkg.sv
// Shared types and constants for the median-filter frame sequencer.
package image_filter_pkg;

   localparam int W_BITS_DEF = 11;
   localparam int H_BITS_DEF = 10;
   localparam int MIN_SIZE   = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/image_pos_counter.sv
// Raster x/y position counter: advances on en, x wraps at width-1,
// and both coordinates return to zero after the last pixel of the frame.
module image_pos_counter #(
   parameter int W_BITS = 11,
   parameter int H_BITS = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   input  logic [W_BITS-1:0] width,
   input  logic [H_BITS-1:0] height,
   output logic [W_BITS-1:0] x,
   output logic [H_BITS-1:0] y,
   output logic              last_x,
   output logic              last_frame
);

   localparam logic [W_BITS-1:0] X_ONE = W_BITS'(1);
   localparam logic [H_BITS-1:0] Y_ONE = H_BITS'(1);

   assign last_x     = (x == width - X_ONE);
   assign last_frame = last_x && (y == height - Y_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (last_x) begin
            x <= '0;
            y <= last_frame ? '0 : y + Y_ONE;
         end else begin
            x <= x + X_ONE;
         end
      end
   end

endmodule

// File: rtl/image_filter_ctrl.sv
// Frame sequencer for the 3x3 median filter: gates W*H source pixels into the
// filter, injects flush lines, counts and tags filter outputs, and supervises completion.
module image_filter_ctrl
   import image_filter_pkg::*;
#(
   parameter int          W_BITS      = W_BITS_DEF,
   parameter int          H_BITS      = H_BITS_DEF,
   parameter int          FLUSH_LINES = 1,
   parameter logic [23:0] FLUSH_VAL   = 24'h000000,
   parameter int          TIMEOUT     = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [W_BITS-1:0]        img_width,
   input  logic [H_BITS-1:0]        img_height,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
   output logic                     timeout_err,
   input  logic                     s_valid,
   input  logic [23:0]              s_data,
   output logic                     s_ready,
   output logic                     f_valid,
   output logic [23:0]              f_data,
   input  logic                     m_valid,
   output logic                     o_keep,
   output logic                     o_sof,
   output logic                     o_eol,
   output logic                     o_eof,
   output logic [W_BITS+H_BITS+3:0] debug
);

   localparam int P_BITS   = W_BITS + H_BITS;
   localparam int FL_BITS  = W_BITS + $clog2(FLUSH_LINES + 1);
   localparam int TMO_BITS = $clog2(TIMEOUT + 1);

   state_t               state;
   logic [W_BITS-1:0]    width_q;
   logic [H_BITS-1:0]    height_q;
   logic [P_BITS-1:0]    out_cnt;
   logic [FL_BITS-1:0]   flush_cnt;
   logic [TMO_BITS-1:0]  tmo_cnt;

   logic [P_BITS-1:0]    total;
   logic [FL_BITS-1:0]   flush_total;
   logic [P_BITS-1:0]    cnt_next;
   logic                 active;
   logic                 accept;
   logic                 size_ok;
   logic                 start_ok;

   logic [W_BITS-1:0]    in_x;
   logic [H_BITS-1:0]    in_y;
   logic                 in_last_x;
   logic                 in_last_frame;
   logic [W_BITS-1:0]    out_x;
   logic [H_BITS-1:0]    out_y;
   logic                 out_last_x;
   logic                 out_last_frame;

   assign total       = P_BITS'(width_q) * P_BITS'(height_q);
   assign flush_total = FL_BITS'(width_q) * FL_BITS'(FLUSH_LINES);
   assign active      = (state == ST_FEED) || (state == ST_FLUSH) || (state == ST_DRAIN);
   assign size_ok     = (img_width >= W_BITS'(MIN_SIZE)) && (img_height >= H_BITS'(MIN_SIZE));
   assign start_ok    = (state == ST_IDLE) && start && size_ok;

   // Source handshake: a pixel transfers on every cycle where s_valid and s_ready
   // are both high; s_ready is high for all of FEED and never depends on s_valid.
   assign s_ready = (state == ST_FEED);
   assign accept  = s_valid && s_ready;

   // Outputs beyond W*H (or outside a frame) belong to nobody and carry no tags.
   assign o_keep   = m_valid && active && (out_cnt < total);
   assign o_sof    = o_keep && (out_x == '0) && (out_y == '0);
   assign o_eol    = o_keep && out_last_x;
   assign o_eof    = o_keep && out_last_frame;
   assign cnt_next = out_cnt + P_BITS'(o_keep);

   assign debug = {state, in_last_x, in_y, in_x};

   image_pos_counter #(.W_BITS(W_BITS), .H_BITS(H_BITS)) u_in_pos (
      .clk        (clk),
      .reset      (reset),
      .en         (accept),
      .clr        (start_ok),
      .width      (width_q),
      .height     (height_q),
      .x          (in_x),
      .y          (in_y),
      .last_x     (in_last_x),
      .last_frame (in_last_frame)
   );

   image_pos_counter #(.W_BITS(W_BITS), .H_BITS(H_BITS)) u_out_pos (
      .clk        (clk),
      .reset      (reset),
      .en         (o_keep),
      .clr        (start_ok),
      .width      (width_q),
      .height     (height_q),
      .x          (out_x),
      .y          (out_y),
      .last_x     (out_last_x),
      .last_frame (out_last_frame)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         out_cnt     <= '0;
         flush_cnt   <= '0;
         tmo_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
         timeout_err <= 1'b0;
         f_valid     <= 1'b0;
         f_data      <= '0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         f_valid <= 1'b0;
         if (o_keep)
            out_cnt <= cnt_next;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (size_ok) begin
                     width_q     <= img_width;
                     height_q    <= img_height;
                     out_cnt     <= '0;
                     flush_cnt   <= '0;
                     tmo_cnt     <= '0;
                     timeout_err <= 1'b0;
                     busy        <= 1'b1;
                     state       <= ST_FEED;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_FEED: begin
               if (accept) begin
                  f_valid <= 1'b1;
                  f_data  <= s_data;
                  if (in_last_frame)
                     state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               f_valid   <= 1'b1;
               f_data    <= FLUSH_VAL;
               flush_cnt <= flush_cnt + FL_BITS'(1);
               if (flush_cnt == flush_total - FL_BITS'(1)) begin
                  tmo_cnt <= '0;
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // The final kept output wins over a same-cycle timeout expiry.
               if (cnt_next == total) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (m_valid) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_BITS'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_BITS'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_filter_ctrl.sv
// Self-checking bench for image_filter_ctrl: frame-level reference model,
// per-cycle compare process, and a simple filter model returning m_valid beats.
module tb_image_filter_ctrl;

   localparam int          W_BITS      = 11;
   localparam int          H_BITS      = 10;
   localparam int          FLUSH_LINES = 1;
   localparam logic [23:0] FLUSH_VAL   = 24'h000000;
   localparam int          TIMEOUT     = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic [W_BITS-1:0]        img_width = '0;
   logic [H_BITS-1:0]        img_height = '0;
   logic                     start = 1'b0;
   logic                     busy, done, cfg_err, timeout_err;
   logic                     s_valid = 1'b0;
   logic [23:0]              s_data = '0;
   logic                     s_ready, f_valid;
   logic [23:0]              f_data;
   logic                     m_valid = 1'b0;
   logic                     o_keep, o_sof, o_eol, o_eof;
   logic [W_BITS+H_BITS+3:0] debug;

   image_filter_ctrl #(
      .W_BITS(W_BITS), .H_BITS(H_BITS), .FLUSH_LINES(FLUSH_LINES),
      .FLUSH_VAL(FLUSH_VAL), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height),
      .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
      .timeout_err(timeout_err), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .f_valid(f_valid), .f_data(f_data), .m_valid(m_valid),
      .o_keep(o_keep), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .debug(debug)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   // Frame progress is tracked as counts: pixels accepted, flush beats sent,
   // outputs kept, and idle drain cycles since the last filter output.
   bit          md_busy, md_done, md_cfg, md_terr, md_fv;
   int          md_w, md_h, md_in, md_fl, md_kept, md_idle;
   logic [23:0] exp_q[$];

   // filter model and per-frame statistics
   int          pend = 0, beat_idx = 0, planned = 0, cap = 0;
   bit          mv_drain_only = 1'b0;
   int          cyc = 0, last_mv_cyc = 0, terr_rise_cyc = 0;
   bit          prev_terr = 1'b0;
   int          st_keep, st_fv, st_flush_zero, st_done, st_mv, st_acc;
   logic [31:0] sof_mask, eol_mask, eof_mask;

   task automatic clear_stats();
      st_keep = 0; st_fv = 0; st_flush_zero = 0; st_done = 0; st_mv = 0; st_acc = 0;
      sof_mask = '0; eol_mask = '0; eof_mask = '0;
      beat_idx = 0; planned = 0; pend = 0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare
      int  total, ftot;
      bit  active, in_feed, in_flush, in_drain, acc;
      bit  e_keep, e_sof, e_eol, e_eof;
      bit  nb, nd, nc, nt, nfv;
      logic [23:0] exp_d;
      if (reset) begin
         md_busy = 0; md_done = 0; md_cfg = 0; md_terr = 0; md_fv = 0;
         md_w = 0; md_h = 0; md_in = 0; md_fl = 0; md_kept = 0; md_idle = 0;
         exp_q.delete();
         prev_terr = 0;
      end else begin
         cyc++;
         total    = md_w * md_h;
         ftot     = md_w * FLUSH_LINES;
         active   = md_busy && !md_done;
         in_feed  = active && (md_in < total);
         in_flush = active && (md_in == total) && (md_fl < ftot);
         in_drain = active && (md_in == total) && (md_fl == ftot);
         e_keep   = m_valid && active && (md_kept < total);
         e_sof    = e_keep && (md_kept == 0);
         e_eol    = e_keep && (md_w != 0) && ((md_kept % md_w) == md_w - 1);
         e_eof    = e_keep && (md_kept == total - 1);

         check("busy",        32'(busy),        32'(md_busy));
         check("done",        32'(done),        32'(md_done));
         check("cfg_err",     32'(cfg_err),     32'(md_cfg));
         check("timeout_err", 32'(timeout_err), 32'(md_terr));
         check("s_ready",     32'(s_ready),     32'(in_feed));
         check("f_valid",     32'(f_valid),     32'(md_fv));
         check("o_keep",      32'(o_keep),      32'(e_keep));
         check("o_sof",       32'(o_sof),       32'(e_sof));
         check("o_eol",       32'(o_eol),       32'(e_eol));
         check("o_eof",       32'(o_eof),       32'(e_eof));
         if (f_valid) begin
            if (exp_q.size() == 0) begin
               check("f_data_unexpected", 32'(1), 32'(0));
            end else begin
               exp_d = exp_q.pop_front();
               check("f_data", 32'(f_data), 32'(exp_d));
            end
         end

         // statistics and filter model input
         if (m_valid) begin st_mv++; last_mv_cyc = cyc; end
         if (timeout_err && !prev_terr) terr_rise_cyc = cyc;
         prev_terr = timeout_err;
         if (done) st_done++;
         if (s_valid && s_ready) st_acc++;
         if (o_keep) begin
            if (o_sof) sof_mask = sof_mask | (32'd1 << st_keep);
            if (o_eol) eol_mask = eol_mask | (32'd1 << st_keep);
            if (o_eof) eof_mask = eof_mask | (32'd1 << st_keep);
            st_keep++;
         end
         if (f_valid) begin
            if (st_fv >= total && f_data == FLUSH_VAL) st_flush_zero++;
            st_fv++;
            beat_idx++;
            if (beat_idx > md_w && planned < cap) begin pend++; planned++; end
         end

         // advance the model across the coming clock edge
         nb = md_busy; nd = 0; nc = 0; nt = md_terr; nfv = 0;
         acc = s_valid && in_feed;
         if (!md_busy) begin
            if (start) begin
               if (img_width >= 3 && img_height >= 3) begin
                  nb = 1; nt = 0;
                  md_w = int'(img_width); md_h = int'(img_height);
                  md_in = 0; md_fl = 0; md_kept = 0; md_idle = 0;
               end else begin
                  nc = 1;
               end
            end
         end else if (md_done) begin
            nb = 0;
         end else begin
            if (acc) begin md_in++; exp_q.push_back(s_data); nfv = 1; end
            if (in_flush) begin md_fl++; exp_q.push_back(FLUSH_VAL); nfv = 1; end
            if (e_keep) md_kept++;
            if (in_drain) begin
               if (md_kept == total) nd = 1;
               else if (m_valid) md_idle = 0;
               else begin
                  md_idle++;
                  if (md_idle == TIMEOUT) begin nt = 1; nd = 1; end
               end
            end else begin
               md_idle = 0;
            end
         end
         md_busy = nb; md_done = nd; md_cfg = nc; md_terr = nt; md_fv = nfv;
      end
   end

   // ---------------- filter model driver ----------------
   function automatic bit mv_allowed();
      return !mv_drain_only ||
             (md_busy && !md_done && md_in == md_w * md_h && md_fl == md_w * FLUSH_LINES);
   endfunction

   always @(posedge clk) begin
      #1;
      if (!reset && pend > 0 && mv_allowed() && $urandom_range(0, 3) != 0) begin
         m_valid = 1'b1;
         pend--;
      end else begin
         m_valid = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int w, input int h);
      @(posedge clk); #1;
      img_width  = W_BITS'(w);
      img_height = H_BITS'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // mode 0: continuous s_valid, 1: toggling 1-0-1, 2: random with stray starts
   task automatic feed(input int w, input int h, input int mode, input int stop_at);
      int n;
      n = 0;
      while (md_in < stop_at && n < 5000) begin
         case (mode)
            0:       s_valid = 1'b1;
            1:       s_valid = (n % 2 == 0);
            default: s_valid = 1'($urandom_range(0, 1));
         endcase
         s_data = 24'($urandom);
         if (mode == 2 && $urandom_range(0, 7) == 0) begin
            start = 1'b1;
            img_width = W_BITS'(2);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      check("feed_bound", 32'(md_in >= stop_at), 32'(1));
      s_valid = 1'b0;
      start   = 1'b0;
      img_width  = W_BITS'(w);
      img_height = H_BITS'(h);
   endtask

   task automatic run_frame(input int w, input int h, input int mode, input int cap_n,
                            input int extra, output bit terr_at_start);
      bit got;
      clear_stats();
      cap = cap_n;
      pulse_start(w, h);
      check("busy_after_start", 32'(busy), 32'(1));
      terr_at_start = timeout_err;
      feed(w, h, mode, w * h);
      got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(posedge clk); #1;
         if (done) got = 1;
      end
      check("done_seen", 32'(got), 32'(1));
      @(posedge clk); #1;
      check("busy_after_done", 32'(busy), 32'(0));
      check("done_one_cycle", 32'(done), 32'(0));
      pend = pend + extra;
      repeat (20) @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      bit terr0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_f_valid", 32'(f_valid), 32'(0));
      check("rst_f_data", 32'(f_data), 32'(0));
      check("rst_timeout_err", 32'(timeout_err), 32'(0));
      @(negedge clk); #1;
      reset = 1'b0;

      // 4x3 frame, continuous source
      run_frame(4, 3, 0, 1 << 30, 0, terr0);
      check("f1_keep", 32'(st_keep), 32'(12));
      check("f1_sof_mask", sof_mask, 32'h001);
      check("f1_eol_mask", eol_mask, 32'h888);
      check("f1_eof_mask", eof_mask, 32'h800);
      check("f1_fv_beats", 32'(st_fv), 32'(16));
      check("f1_flush_beats", 32'(st_flush_zero), 32'(4));
      check("f1_done_pulses", 32'(st_done), 32'(1));

      // 4x3 frame, toggling source
      run_frame(4, 3, 1, 1 << 30, 0, terr0);
      check("f2_accepted", 32'(st_acc), 32'(12));
      check("f2_fv_beats", 32'(st_fv), 32'(16));
      check("f2_keep", 32'(st_keep), 32'(12));

      // rejected configurations
      pulse_start(2, 3);
      check("cfg_w2_err", 32'(cfg_err), 32'(1));
      check("cfg_w2_busy", 32'(busy), 32'(0));
      check("cfg_w2_ready", 32'(s_ready), 32'(0));
      @(posedge clk); #1;
      check("cfg_w2_pulse", 32'(cfg_err), 32'(0));
      pulse_start(5, 2);
      check("cfg_h2_err", 32'(cfg_err), 32'(1));
      check("cfg_h2_busy", 32'(busy), 32'(0));

      // filter stalls after 10 outputs
      mv_drain_only = 1'b1;
      run_frame(4, 3, 0, 10, 0, terr0);
      mv_drain_only = 1'b0;
      check("to_keep", 32'(st_keep), 32'(10));
      check("to_err", 32'(timeout_err), 32'(1));
      check("to_gap", 32'(terr_rise_cyc - last_mv_cyc - 1), 32'(TIMEOUT));
      check("to_done_pulses", 32'(st_done), 32'(1));

      // surplus outputs beyond the frame; start also clears timeout_err
      run_frame(4, 3, 0, 1 << 30, 2, terr0);
      check("clr_terr", 32'(terr0), 32'(0));
      check("xs_keep", 32'(st_keep), 32'(12));
      check("xs_mv", 32'(st_mv), 32'(14));

      // reset in the middle of FEED
      clear_stats();
      cap = 1 << 30;
      pulse_start(4, 3);
      feed(4, 3, 0, 5);
      pend = 0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_s_ready", 32'(s_ready), 32'(0));
      check("mid_rst_f_valid", 32'(f_valid), 32'(0));
      check("mid_rst_f_data", 32'(f_data), 32'(0));
      check("mid_rst_keep", 32'({o_keep, o_sof, o_eol, o_eof}), 32'(0));
      check("mid_rst_done", 32'({done, cfg_err, timeout_err}), 32'(0));
      @(negedge clk); #1;
      reset = 1'b0;
      run_frame(4, 3, 0, 1 << 30, 0, terr0);
      check("post_rst_keep", 32'(st_keep), 32'(12));
      check("post_rst_eof", eof_mask, 32'h800);

      // random sizes and source patterns
      for (int f = 0; f < 5; f++) begin
         int w, h;
         w = $urandom_range(3, 7);
         h = $urandom_range(3, 5);
         run_frame(w, h, 2, 1 << 30, $urandom_range(0, 2), terr0);
         check("rnd_keep", 32'(st_keep), 32'(w * h));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
